// File: rtl/smbm_arb_pkg.sv
// Shared types and opcode constants for the smbm command arbiter.
// Optional WAIT timeout is enabled by defining SMBM_ARB_TIMEOUT_EN.
package smbm_arb_pkg;

    typedef enum logic [1:0] {
        OP_ADD    = 2'd0,
        OP_DELETE = 2'd1,
        OP_READ   = 2'd2,
        OP_RSVD   = 2'd3
    } req_op_e;

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_FULL  = 2'd1,
        ST_EMPTY = 2'd2,
        ST_ERR   = 2'd3
    } rsp_status_e;

    localparam logic [2:0] SMBM_OP_ADD  = 3'b000;
    localparam logic [2:0] SMBM_OP_DEL  = 3'b001;
    localparam logic [2:0] SMBM_OP_READ = 3'b010;
    localparam logic [2:0] SMBM_OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    function automatic logic [2:0] smbm_op_of(input req_op_e op);
        case (op)
            OP_ADD:    return SMBM_OP_ADD;
            OP_DELETE: return SMBM_OP_DEL;
            OP_READ:   return SMBM_OP_READ;
            default:   return SMBM_OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/smbm_cmd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first pending request at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int REQ_LOG = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_LOG-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [REQ_LOG-1:0] grant_idx,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] rot;

    // rot[k] is the request k positions after the pointer.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = req[REQ_LOG'((int'(ptr) + gi) % NUM_REQ)];
        end
    endgenerate

    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any_valid && rot[k]) begin
                any_valid = 1'b1;
                grant_idx = REQ_LOG'((int'(ptr) + k) % NUM_REQ);
            end
        end
        grant = any_valid ? (NUM_REQ'(1) << grant_idx) : '0;
    end

endmodule

// File: rtl/smbm_cmd_arbiter.sv
// Round-robin command front end for smbm: grant, issue, wait for done, respond.
// Define SMBM_ARB_TIMEOUT_EN to abort a WAIT after TIMEOUT_CYC cycles with ERR.
module smbm_cmd_arbiter
    import smbm_arb_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int REQ_LOG            = 2,
    parameter int BIT_VEC_SIZE       = 64,
    parameter int BIT_VEC_SIZE_LOG   = 6,
    parameter int NUM_OF_METRICS     = 4,
    parameter int NUM_OF_METRICS_LOG = 2
`ifdef SMBM_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC        = 16
`endif
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ-1:0][1:0]                    req_op,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE_LOG-1:0]   req_id,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS-1:0][7:0] req_metric,
    input  logic [NUM_REQ-1:0][BIT_VEC_SIZE-1:0]       req_in,
    input  logic [NUM_REQ-1:0][NUM_OF_METRICS_LOG-1:0] req_metricX,
    input  logic [NUM_REQ-1:0][2:0]                    req_mode,
    output logic                                       rsp_valid,
    output logic [REQ_LOG-1:0]                         rsp_req,
    output logic [1:0]                                 rsp_status,
    output logic [BIT_VEC_SIZE_LOG:0]                  occupancy,
    output logic [2:0]                                 smbm_opcode,
    output logic [BIT_VEC_SIZE_LOG-1:0]                smbm_id,
    output logic [NUM_OF_METRICS-1:0][7:0]             smbm_metric_val,
    output logic [BIT_VEC_SIZE-1:0]                    smbm_in,
    output logic [NUM_OF_METRICS_LOG-1:0]              smbm_metricX,
    output logic [2:0]                                 smbm_opcode_in,
    input  logic                                       smbm_done
);

    localparam logic [BIT_VEC_SIZE_LOG:0] OCC_FULL = (BIT_VEC_SIZE_LOG+1)'(BIT_VEC_SIZE);

    state_e               state_reg;
    req_op_e              op_reg;
    logic [REQ_LOG-1:0]   rr_ptr_reg;
    logic [NUM_REQ-1:0]   grant;
    logic [REQ_LOG-1:0]   grant_idx;
    logic                 any_valid;
    req_op_e              grant_op;

`ifdef SMBM_ARB_TIMEOUT_EN
    logic [$clog2(TIMEOUT_CYC+1)-1:0] wait_cnt_reg;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .REQ_LOG (REQ_LOG)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    assign grant_op = req_op_e'(req_op[grant_idx]);

    always_comb begin
        req_ready = '0;
        if (state_reg == S_IDLE && !rst)
            req_ready = grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            op_reg          <= OP_ADD;
            rr_ptr_reg      <= '0;
            occupancy       <= '0;
            rsp_valid       <= 1'b0;
            rsp_req         <= '0;
            rsp_status      <= ST_OK;
            smbm_opcode     <= SMBM_OP_NOP;
            smbm_id         <= '0;
            smbm_metric_val <= '0;
            smbm_in         <= '0;
            smbm_metricX    <= '0;
            smbm_opcode_in  <= '0;
`ifdef SMBM_ARB_TIMEOUT_EN
            wait_cnt_reg    <= '0;
`endif
        end else begin
            rsp_valid   <= 1'b0;
            smbm_opcode <= SMBM_OP_NOP;
            case (state_reg)
                S_IDLE: begin
                    if (any_valid) begin
                        op_reg          <= grant_op;
                        rsp_req         <= grant_idx;
                        smbm_id         <= req_id[grant_idx];
                        smbm_metric_val <= req_metric[grant_idx];
                        smbm_in         <= req_in[grant_idx];
                        smbm_metricX    <= req_metricX[grant_idx];
                        smbm_opcode_in  <= req_mode[grant_idx];
                        rr_ptr_reg      <= (int'(grant_idx) == NUM_REQ-1) ? '0 : grant_idx + 1'b1;
                        // Rejections skip smbm entirely and respond next cycle.
                        if (grant_op == OP_ADD && occupancy == OCC_FULL) begin
                            rsp_status <= ST_FULL;
                            rsp_valid  <= 1'b1;
                            state_reg  <= S_RESP;
                        end else if (grant_op == OP_DELETE && occupancy == '0) begin
                            rsp_status <= ST_EMPTY;
                            rsp_valid  <= 1'b1;
                            state_reg  <= S_RESP;
                        end else if (grant_op == OP_RSVD) begin
                            rsp_status <= ST_ERR;
                            rsp_valid  <= 1'b1;
                            state_reg  <= S_RESP;
                        end else begin
                            smbm_opcode <= smbm_op_of(grant_op);
                            state_reg   <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef SMBM_ARB_TIMEOUT_EN
                    // Counts cycles since ISSUE, so RESP lands TIMEOUT_CYC after it.
                    wait_cnt_reg <= 1;
`endif
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (smbm_done) begin
                        rsp_status <= ST_OK;
                        rsp_valid  <= 1'b1;
                        state_reg  <= S_RESP;
                        if (op_reg == OP_ADD)
                            occupancy <= occupancy + 1'b1;
                        else if (op_reg == OP_DELETE)
                            occupancy <= occupancy - 1'b1;
                    end
`ifdef SMBM_ARB_TIMEOUT_EN
                    else if (int'(wait_cnt_reg) >= TIMEOUT_CYC-1) begin
                        rsp_status <= ST_ERR;
                        rsp_valid  <= 1'b1;
                        state_reg  <= S_RESP;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_smbm_cmd_arbiter.sv
// Scoreboard bench for smbm_cmd_arbiter with a fixed-latency smbm done stub.
`timescale 1ns/1ps
module tb_smbm_cmd_arbiter;
    import smbm_arb_pkg::*;

    localparam int NR  = 4;
    localparam int RL  = 2;
    localparam int BV  = 64;
    localparam int BVL = 6;
    localparam int NM  = 4;
    localparam int NML = 2;
`ifdef SMBM_ARB_TIMEOUT_EN
    localparam int TIMEOUT_CYC = 16;
`endif

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NR-1:0]                 req_valid;
    logic [NR-1:0]                 req_ready;
    logic [NR-1:0][1:0]            req_op;
    logic [NR-1:0][BVL-1:0]        req_id;
    logic [NR-1:0][NM-1:0][7:0]    req_metric;
    logic [NR-1:0][BV-1:0]         req_in;
    logic [NR-1:0][NML-1:0]        req_metricX;
    logic [NR-1:0][2:0]            req_mode;
    logic                          rsp_valid;
    logic [RL-1:0]                 rsp_req;
    logic [1:0]                    rsp_status;
    logic [BVL:0]                  occupancy;
    logic [2:0]                    smbm_opcode;
    logic [BVL-1:0]                smbm_id;
    logic [NM-1:0][7:0]            smbm_metric_val;
    logic [BV-1:0]                 smbm_in;
    logic [NML-1:0]                smbm_metricX;
    logic [2:0]                    smbm_opcode_in;
    logic                          smbm_done;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    smbm_cmd_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_id          (req_id),
        .req_metric      (req_metric),
        .req_in          (req_in),
        .req_metricX     (req_metricX),
        .req_mode        (req_mode),
        .rsp_valid       (rsp_valid),
        .rsp_req         (rsp_req),
        .rsp_status      (rsp_status),
        .occupancy       (occupancy),
        .smbm_opcode     (smbm_opcode),
        .smbm_id         (smbm_id),
        .smbm_metric_val (smbm_metric_val),
        .smbm_in         (smbm_in),
        .smbm_metricX    (smbm_metricX),
        .smbm_opcode_in  (smbm_opcode_in),
        .smbm_done       (smbm_done)
    );

    // smbm stub: READ done the cycle after the opcode, ADD/DELETE one cycle later.
    logic stub_mute = 1'b0;
    logic stub_pend;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            smbm_done <= 1'b0;
            stub_pend <= 1'b0;
        end else begin
            smbm_done <= 1'b0;
            stub_pend <= 1'b0;
            if (!stub_mute) begin
                if (smbm_opcode == 3'b010) smbm_done <= 1'b1;
                if (smbm_opcode == 3'b000 || smbm_opcode == 3'b001) stub_pend <= 1'b1;
                if (stub_pend) smbm_done <= 1'b1;
            end
        end
    end

    typedef struct {
        int          req;
        logic [1:0]  status;
        int          due;
        int          occ;
    } rsp_exp_t;

    typedef struct {
        logic [2:0]  code;
        int          due;
        logic [5:0]  id;
        logic [31:0] metric;
    } op_exp_t;

    rsp_exp_t rsp_q[$];
    op_exp_t  op_q[$];
    int       grants_seen[$];
    int       model_occ = 0;
    int       n_cmp = 0;
    int       n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] op, input logic [5:0] id,
                           input logic [31:0] metric, input logic [2:0] mode);
        req_op[r]      = op;
        req_id[r]      = id;
        req_metric[r]  = metric;
        req_in[r]      = {16'hA5A5, 42'd0, id};
        req_metricX[r] = 2'(r);
        req_mode[r]    = mode;
        req_valid[r]   = 1'b1;
    endtask

    // Expected outcome of a grant, built from the request and a bench occupancy model.
    task automatic note_grant(input int g, input bit push_rsp);
        rsp_exp_t re;
        op_exp_t  oe;
        logic [1:0] op;
        op = req_op[g];
        re.req = g;
        if (op == 2'd0 && model_occ == BV) begin
            re.status = 2'd1; re.due = cyc + 1;
        end else if (op == 2'd1 && model_occ == 0) begin
            re.status = 2'd2; re.due = cyc + 1;
        end else if (op == 2'd3) begin
            re.status = 2'd3; re.due = cyc + 1;
        end else begin
            oe.code   = (op == 2'd0) ? 3'b000 : (op == 2'd1) ? 3'b001 : 3'b010;
            oe.due    = cyc + 1;
            oe.id     = req_id[g];
            oe.metric = req_metric[g];
            op_q.push_back(oe);
            re.status = 2'd0;
            re.due    = cyc + ((op == 2'd2) ? 3 : 4);
`ifdef SMBM_ARB_TIMEOUT_EN
            if (stub_mute) begin
                re.status = 2'd3;
                re.due    = cyc + 1 + TIMEOUT_CYC;
            end
`endif
            if (re.status == 2'd0 && op == 2'd0) model_occ++;
            if (re.status == 2'd0 && op == 2'd1) model_occ--;
        end
        re.occ = model_occ;
        if (push_rsp) rsp_q.push_back(re);
        grants_seen.push_back(g);
    endtask

    // Serve all pending requests; returns at a negedge once everything has drained.
    task automatic run(input int budget);
        int g;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                chk("ready_onehot", 64'($countones(req_ready)), 64'd1);
                g = 0;
                for (int k = 0; k < NR; k++) if (req_ready[k]) g = k;
                note_grant(g, 1'b1);
                @(posedge clk);
                #1 req_valid[g] = 1'b0;
            end
            if (req_valid == '0 && rsp_q.size() == 0 && op_q.size() == 0) return;
        end
        n_cmp++;
        n_bad++;
        $display("FAIL run_budget: got pending=%0d/%0d/%0h, expected drained within %0d cycles",
                 rsp_q.size(), op_q.size(), req_valid, budget);
        rsp_q.delete();
        op_q.delete();
        req_valid = '0;
    endtask

    // Monitor: every response and every opcode pulse must match the head of its queue.
    initial begin
        rsp_exp_t re;
        op_exp_t  oe;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rsp_valid) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 64'(rsp_req), 64'hFFFF);
                    end else begin
                        re = rsp_q.pop_front();
                        chk("rsp_req", 64'(rsp_req), 64'(re.req));
                        chk("rsp_status", 64'(rsp_status), 64'(re.status));
                        chk("rsp_cycle", 64'(cyc), 64'(re.due));
                        chk("rsp_occupancy", 64'(occupancy), 64'(re.occ));
                        $display("rsp req=%0d status=%0d occ=%0d cycle=%0d",
                                 rsp_req, rsp_status, occupancy, cyc);
                    end
                end
                if (smbm_opcode != 3'b111) begin
                    if (op_q.size() == 0) begin
                        chk("opcode_unexpected", 64'(smbm_opcode), 64'h7);
                    end else begin
                        oe = op_q.pop_front();
                        chk("smbm_opcode", 64'(smbm_opcode), 64'(oe.code));
                        chk("opcode_cycle", 64'(cyc), 64'(oe.due));
                        chk("smbm_id", 64'(smbm_id), 64'(oe.id));
                        chk("smbm_metric_val", 64'(smbm_metric_val), 64'(oe.metric));
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0;
        rst         = 1'b1;
        req_valid   = '0;
        req_op      = '0;
        req_id      = '0;
        req_metric  = '0;
        req_in      = '0;
        req_metricX = '0;
        req_mode    = '0;

        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_req_ready", 64'(req_ready), 64'd0);
        chk("reset_opcode", 64'(smbm_opcode), 64'h7);
        chk("reset_occupancy", 64'(occupancy), 64'd0);
        chk("reset_smbm_id", 64'(smbm_id), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Empty: DELETE with nothing in the list.
        set_req(0, 2'd1, 6'd3, 32'd0, 3'b000);
        run(20);

        // Single ADD, then ADD id 7 / DELETE id 7.
        grants_seen.delete();
        set_req(0, 2'd0, 6'd5, {8'd40, 8'd30, 8'd20, 8'd10}, 3'b000);
        run(20);
        chk("single_add_grant", 64'(grants_seen[0]), 64'd0);
        set_req(0, 2'd0, 6'd7, {8'd1, 8'd2, 8'd3, 8'd4}, 3'b000);
        run(20);
        set_req(0, 2'd1, 6'd7, 32'd0, 3'b000);
        run(20);

        // Move the pointer to 2, then all four READ at once.
        set_req(1, 2'd2, 6'd9, 32'd0, 3'b101);
        run(20);
        grants_seen.delete();
        for (int r = 0; r < NR; r++) set_req(r, 2'd2, 6'(r + 20), 32'(r), 3'b010);
        run(80);
        chk("contention_count", 64'(grants_seen.size()), 64'd4);
        if (grants_seen.size() == 4) begin
            chk("contention_g0", 64'(grants_seen[0]), 64'd2);
            chk("contention_g1", 64'(grants_seen[1]), 64'd3);
            chk("contention_g2", 64'(grants_seen[2]), 64'd0);
            chk("contention_g3", 64'(grants_seen[3]), 64'd1);
        end

        // Reserved op.
        set_req(2, 2'd3, 6'd1, 32'd0, 3'b000);
        run(20);

        // Async reset during WAIT.
        set_req(0, 2'd0, 6'd11, 32'h0102_0304, 3'b000);
        g0 = 0;
        for (int i = 0; i < 20 && g0 == 0; i++) begin
            @(negedge clk);
            if (req_ready[0]) g0 = 1;
        end
        chk("rstwait_granted", 64'(g0), 64'd1);
        note_grant(0, 1'b0);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstwait_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstwait_opcode", 64'(smbm_opcode), 64'h7);
        chk("rstwait_occupancy", 64'(occupancy), 64'd0);
        chk("rstwait_smbm_id", 64'(smbm_id), 64'd0);
        model_occ = 0;
        rsp_q.delete();
        op_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        grants_seen.delete();
        set_req(1, 2'd2, 6'd2, 32'd0, 3'b010);
        set_req(0, 2'd2, 6'd1, 32'd0, 3'b010);
        run(40);
        chk("rstwait_order_count", 64'(grants_seen.size()), 64'd2);
        if (grants_seen.size() == 2) begin
            chk("rstwait_first_grant", 64'(grants_seen[0]), 64'd0);
            chk("rstwait_second_grant", 64'(grants_seen[1]), 64'd1);
        end

        // Full: 64 ADDs fill the list, the 65th is rejected.
        for (int i = 0; i < BV; i++) begin
            set_req(i % NR, 2'd0, 6'(i), 32'(i * 3), 3'b000);
            run(30);
        end
        chk("full_occupancy", 64'(occupancy), 64'd64);
        set_req(3, 2'd0, 6'd63, 32'd0, 3'b000);
        run(20);
        chk("full_occupancy_after", 64'(occupancy), 64'd64);

`ifdef SMBM_ARB_TIMEOUT_EN
        stub_mute = 1'b1;
        set_req(3, 2'd2, 6'd4, 32'd0, 3'b010);
        run(60);
        stub_mute = 1'b0;
        chk("timeout_occupancy", 64'(occupancy), 64'd64);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
